// File: rtl/range_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3) for the ultrasonic range value.
// Optional macro RANGE_BCD_SAT_EN: on overflow the result saturates to all nines.
module range_bcd_conv #(
  parameter int RANGE_WIDTH = 32,
  parameter int DIGITS      = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RANGE_WIDTH-1:0] range,
  output logic [4*DIGITS-1:0]    bcd,
  output logic                   valid,
  output logic                   busy,
  output logic                   overflow
);

  localparam int          BW    = 4 * DIGITS;
  localparam int          CW    = $clog2(RANGE_WIDTH + 1);
  localparam logic [63:0] LIMIT = 64'(10 ** DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t                 state_q;
  logic [RANGE_WIDTH-1:0] src_last_q;
  logic [RANGE_WIDTH-1:0] shift_q;
  logic [RANGE_WIDTH-1:0] shift_d;
  logic [BW-1:0]          work_q;
  logic [BW-1:0]          work_adj;
  logic [BW-1:0]          work_d;
  logic [CW-1:0]          cnt_q;
  logic                   ovf_pend_q;
  logic                   range_ovf_d;
  logic [BW-1:0]          bcd_q;
  logic                   valid_q;
  logic                   overflow_q;

  // Digits above the top one are dropped, giving range mod 10^DIGITS.
  always_comb begin
    work_adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
    work_d      = {work_adj[BW-2:0], shift_q[RANGE_WIDTH-1]};
    shift_d     = {shift_q[RANGE_WIDTH-2:0], 1'b0};
    range_ovf_d = (64'(range) >= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      src_last_q <= '0;
      shift_q    <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (range != src_last_q) begin
            src_last_q <= range;
            shift_q    <= range;
            work_q     <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= range_ovf_d;
            state_q    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          work_q  <= work_d;
          shift_q <= shift_d;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(RANGE_WIDTH - 1)) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
`ifdef RANGE_BCD_SAT_EN
          bcd_q <= ovf_pend_q ? {DIGITS{4'h9}} : work_q;
`else
          bcd_q <= work_q;
`endif
          overflow_q <= ovf_pend_q;
          valid_q    <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bcd      = bcd_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_range_bcd_conv.sv
// Directed bench for range_bcd_conv at default parameters (32-bit range, 4 digits).
// Expected values follow RANGE_BCD_SAT_EN when the macro is defined for the build.
module tb_range_bcd_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] range;
  logic [15:0] bcd;
  logic        valid;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  range_bcd_conv #(.RANGE_WIDTH(32), .DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .range    (range),
    .bcd      (bcd),
    .valid    (valid),
    .busy     (busy),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply a new value, then expect busy right after capture and one valid pulse 33 clocks later.
  task automatic conv(input logic [31:0] val, input logic [15:0] exp_bcd,
                      input logic exp_ovf, input string tag);
    int n;
    range = val;
    tick();
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_bcd"}, 64'(bcd), 64'(exp_bcd));
    check({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
    tick();
    check({tag, "_pulse1"}, 64'(valid), 64'd0);
    check({tag, "_hold"}, 64'(bcd), 64'(exp_bcd));
  endtask

  initial begin
    int bad_valid;
    int bad_busy;
    int pulses;
    int k1;
    int k2;
    logic [15:0] v1;
    logic [15:0] v2;
    logic saw200;

    rst   = 1'b1;
    range = '0;
    bad_valid = 0;
    bad_busy  = 0;
    repeat (100) begin
      tick();
      if (valid) bad_valid++;
      if (busy) bad_busy++;
    end
    rst = 1'b0;
    repeat (5) begin
      tick();
      if (valid) bad_valid++;
      if (busy) bad_busy++;
    end
    check("reset_bcd", 64'(bcd), 64'h0);
    check("reset_valid_never", 64'(bad_valid), 64'd0);
    check("reset_busy_never", 64'(bad_busy), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);

    conv(32'd1234, 16'h1234, 1'b0, "c1234");
    conv(32'd9999, 16'h9999, 1'b0, "c9999");
`ifdef RANGE_BCD_SAT_EN
    conv(32'd10000, 16'h9999, 1'b1, "c10000");
    conv(32'd12345, 16'h9999, 1'b1, "c12345");
    conv(32'hFFFF_FFFF, 16'h9999, 1'b1, "cmax");
`else
    conv(32'd10000, 16'h0000, 1'b1, "c10000");
    conv(32'd12345, 16'h2345, 1'b1, "c12345");
    conv(32'hFFFF_FFFF, 16'h7295, 1'b1, "cmax");
`endif
    conv(32'd0, 16'h0000, 1'b0, "c0");

    // Updates while busy: only the latest value gets converted afterwards.
    range  = 32'd100;
    tick();
    pulses = 0;
    k1 = 0;
    k2 = 0;
    v1 = '0;
    v2 = '0;
    saw200 = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      if (k == 5) range = 32'd200;
      if (k == 10) range = 32'd300;
      tick();
      if (bcd == 16'h0200) saw200 = 1'b1;
      if (valid) begin
        pulses++;
        if (pulses == 1) begin v1 = bcd; k1 = k; end
        else if (pulses == 2) begin v2 = bcd; k2 = k; end
      end
    end
    check("busy_pulses", 64'(pulses), 64'd2);
    check("busy_first", 64'(v1), 64'h0100);
    check("busy_second", 64'(v2), 64'h0300);
    check("busy_b2b_gap", 64'(k2 - k1), 64'd34);
    check("busy_no200", 64'(saw200), 64'd0);

    // Reset in the middle of a shift sequence, then restart.
    range = 32'd42;
    tick();
    repeat (10) tick();
    check("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    check("midrst_bcd", 64'(bcd), 64'h0);
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    conv(32'd42, 16'h0042, 1'b0, "rst_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/range_bcd_conv.md
RANGE_BCD_CONV -- requirements
Module: range_bcd_conv

Interface
REQ-001 Parameter RANGE_WIDTH, default 32, SHALL set the binary range input width.
REQ-002 Parameter DIGITS, default 4, legal 1..8, SHALL set the number of BCD output digits.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 range  input  RANGE_WIDTH  SHALL be the binary measurement from the ultrasonic FSM output buffer, held stable between updates.
REQ-006 bcd  output  4*DIGITS  SHALL be the packed BCD result, digit 0 (units) in bits [3:0].
REQ-007 valid  output  1  SHALL pulse high for exactly one cycle when bcd/overflow are updated.
REQ-008 busy  output  1  SHALL be high while a conversion is in progress.
REQ-009 overflow  output  1  SHALL be high when the last converted value is >= 10^DIGITS.

Function
REQ-010 The FSM SHALL have states S_IDLE, S_SHIFT and S_DONE; busy = (state != S_IDLE).
REQ-011 An internal register src_last SHALL hold the last captured range value.
REQ-012 In S_IDLE, when range != src_last, the block SHALL capture range into a shift register and src_last, clear the BCD work register and bit counter, and go to S_SHIFT.
REQ-013 In S_IDLE with range == src_last, no action SHALL occur.
REQ-014 In S_SHIFT, each cycle SHALL:
- add 3 to every work digit >= 5;
- shift work||binary left by one, binary MSB entering work bit 0;
- increment the bit counter.
REQ-015 After exactly RANGE_WIDTH shift cycles the FSM SHALL go to S_DONE.
REQ-016 S_DONE SHALL last one cycle.
REQ-017 On the edge leaving S_DONE, bcd, overflow and a registered valid SHALL load, and the FSM SHALL return to S_IDLE.
REQ-018 Latency: valid and the new bcd SHALL be visible RANGE_WIDTH+1 clocks after the capturing edge (33 at default).
REQ-019 The work register SHALL be truncated to 4*DIGITS bits, so without saturation bcd = range mod 10^DIGITS.
REQ-020 overflow SHALL be computed from the captured value (>= 10^DIGITS), independent of RANGE_BCD_SAT_EN.
REQ-021 Changes of range while busy SHALL be ignored; the S_IDLE compare SHALL then convert the latest value, so intermediate values may be skipped but the final value is always converted.
REQ-022 A new capture SHALL be allowed in the same cycle that valid is high.
REQ-023 bcd and overflow SHALL hold their values between valid pulses.

Reset
REQ-024 rst SHALL force state S_IDLE, bcd=0, valid=0, overflow=0, src_last=0, and clear the work and shift registers and bit counter, including mid-conversion.
REQ-025 After reset release with range != 0, a conversion SHALL start on the first clock edge with rst low.

Configuration
REQ-026 Macro RANGE_BCD_SAT_EN defined: on overflow, bcd SHALL load all digits = 9.
REQ-027 Macro RANGE_BCD_SAT_EN undefined: bcd SHALL load the truncated value (range mod 10^DIGITS); overflow behaves identically in both builds.

Verification (defaults RANGE_WIDTH=32, DIGITS=4)
REQ-028 Reset with range=0 held for 100 cycles -> bcd=0x0000, valid never high, busy=0.
REQ-029 range 0->1234 -> busy high the cycle after capture; one valid pulse 33 clocks after the capture edge; bcd=0x1234; overflow=0.
REQ-030 range=9999 then 10000 -> first 0x9999, overflow=0; second overflow=1 with bcd=0x9999 (SAT_EN) or 0x0000 (no SAT_EN); range=12345 without SAT_EN -> 0x2345.
REQ-031 range=100; while busy, 200 then 300 -> two valid pulses: bcd=0x0100, then 0x0300; 0x0200 never appears.
REQ-032 range=42, rst asserted during S_SHIFT -> next cycle bcd=0, valid=0, busy=0; after release, conversion restarts; valid with bcd=0x0042.
